rc4_prga_decrypt: RTL and testbench

Decrypt stage of one key-search core. It takes an S array that the upstream KSA phase has already keyed in s_memory and runs the RC4 PRGA over the MSG_LEN-byte ciphertext in rom_memory. It writes each plaintext byte to decrypt_ram and checks each byte against the allowed character set. Early abort and pass/fail reporting let the core's key-search loop move to the next key as soon as a byte fails.

---
 rtl/rc4_prga_decrypt_if.sv | 31 +++
 rtl/rc4_prga_decrypt.sv | 140 ++++++++++++++
 tb/tb_rc4_prga_decrypt.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/rc4_prga_decrypt_if.sv
// Control handshake and memory-port bundle for the RC4 PRGA decrypt stage.
// master = key-search controller plus the S/ROM/decrypt memories,
// slave  = the decrypt engine.
interface rc4_prga_decrypt_if #(parameter int ADDR_W = 5);
  logic              start;
  logic              halt;
  logic              done;
  logic              valid;
  logic [ADDR_W:0]   bytes_done;
  logic [7:0]        s_address;
  logic [7:0]        s_data;
  logic              s_wren;
  logic [7:0]        s_q;
  logic [ADDR_W-1:0] rom_address;
  logic [7:0]        rom_q;
  logic [ADDR_W-1:0] decrypt_address;
  logic [7:0]        decrypt_data;
  logic              decrypt_wren;

  modport master (
    output start, halt, s_q, rom_q,
    input  done, valid, bytes_done, s_address, s_data, s_wren,
           rom_address, decrypt_address, decrypt_data, decrypt_wren
  );

  modport slave (
    input  start, halt, s_q, rom_q,
    output done, valid, bytes_done, s_address, s_data, s_wren,
           rom_address, decrypt_address, decrypt_data, decrypt_wren
  );
endinterface

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA decrypt stage: walks a pre-keyed S array over MSG_LEN ciphertext
// bytes, writes plaintext out and aborts on the first byte outside the
// allowed character set. Nine cycles per byte against 1-cycle-latency RAMs.
module rc4_prga_decrypt #(
  parameter int         MSG_LEN    = 32,
  parameter int         ADDR_W     = 5,
  parameter logic [7:0] LO_CHAR    = 8'h61,
  parameter logic [7:0] HI_CHAR    = 8'h7A,
  parameter logic [7:0] SPACE_CHAR = 8'h20
) (
  input logic               clock,
  input logic               reset,
  rc4_prga_decrypt_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, READ_I, CAP_I, READ_J, CAP_J, WRITE_I, WRITE_J,
    READ_F, CAP_F, WRITE_OUT, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(MSG_LEN - 1);

  state_t            state, state_nx;
  logic [7:0]        i, j, si, sj, enc, pt;
  logic [ADDR_W-1:0] k;
  logic              valid_r;
  logic [ADDR_W:0]   bytes_done_r;
  logic              pt_legal, last_byte;

  assign pt_legal  = ((pt >= LO_CHAR) && (pt <= HI_CHAR)) || (pt == SPACE_CHAR);
  assign last_byte = (k == K_LAST);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state: fixed 9-step byte walk; halt overrides everything.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (bus.start) state_nx = READ_I;
      READ_I:    state_nx = CAP_I;
      CAP_I:     state_nx = READ_J;
      READ_J:    state_nx = CAP_J;
      CAP_J:     state_nx = WRITE_I;
      WRITE_I:   state_nx = WRITE_J;
      WRITE_J:   state_nx = READ_F;
      READ_F:    state_nx = CAP_F;
      CAP_F:     state_nx = WRITE_OUT;
      WRITE_OUT: state_nx = (!pt_legal || last_byte) ? DONE : READ_I;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
    if (bus.halt) state_nx = IDLE;
  end

  // Datapath registers; a halted cycle commits nothing so valid is preserved.
  always_ff @(posedge clock) begin
    if (reset) begin
      i            <= '0;
      j            <= '0;
      k            <= '0;
      si           <= '0;
      sj           <= '0;
      enc          <= '0;
      pt           <= '0;
      valid_r      <= 1'b0;
      bytes_done_r <= '0;
    end else if (!bus.halt) begin
      case (state)
        IDLE: if (bus.start) begin
          i            <= 8'd1;
          j            <= '0;
          k            <= '0;
          bytes_done_r <= '0;
          valid_r      <= 1'b0;
        end
        CAP_I: begin
          si  <= bus.s_q;
          enc <= bus.rom_q;
          j   <= j + bus.s_q;
        end
        CAP_J: sj <= bus.s_q;
        CAP_F: pt <= bus.s_q ^ enc;
        WRITE_OUT: begin
          bytes_done_r <= bytes_done_r + 1'b1;
          if (!pt_legal)      valid_r <= 1'b0;
          else if (last_byte) valid_r <= 1'b1;
          else begin
            i <= i + 8'd1;
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; write enables and done drop in a halt cycle.
  always_comb begin
    bus.s_address       = '0;
    bus.s_data          = '0;
    bus.s_wren          = 1'b0;
    bus.rom_address     = '0;
    bus.decrypt_address = '0;
    bus.decrypt_data    = '0;
    bus.decrypt_wren    = 1'b0;
    case (state)
      READ_I: begin
        bus.s_address   = i;
        bus.rom_address = k;
      end
      READ_J: bus.s_address = j;
      WRITE_I: begin
        bus.s_address = i;
        bus.s_data    = sj;
        bus.s_wren    = !bus.halt;
      end
      WRITE_J: begin
        bus.s_address = j;
        bus.s_data    = si;
        bus.s_wren    = !bus.halt;
      end
      READ_F: bus.s_address = si + sj;
      WRITE_OUT: begin
        bus.decrypt_address = k;
        bus.decrypt_data    = pt;
        bus.decrypt_wren    = !bus.halt;
      end
      default: ;
    endcase
  end

  assign bus.done       = (state == DONE) && !bus.halt;
  assign bus.valid      = valid_r;
  assign bus.bytes_done = bytes_done_r;

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Directed bench for rc4_prga_decrypt: hand-computed short vectors, a
// reference-RC4 crafted 32-byte pass, halt, mid-run reset and stray start.
module tb_rc4_prga_decrypt;
  localparam int MSG_LEN = 32;
  localparam int ADDR_W  = 5;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rc4_prga_decrypt_if #(.ADDR_W(ADDR_W)) bus();

  rc4_prga_decrypt #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // memory images and model state
  logic [7:0] s_mem   [256];
  logic [7:0] s_init  [256];
  logic [7:0] ms      [256];
  logic [7:0] rom_mem [32];
  logic [7:0] rom_init[32];
  logic [7:0] dec_mem [32];
  logic [7:0] exp_pt  [32];
  logic       load = 1'b0;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         dual_wren = 0;

  // synchronous RAM/ROM models, 1-cycle read latency; load copies images in
  always @(posedge clock) begin
    if (load) begin
      for (int a = 0; a < 256; a++) s_mem[8'(a)] <= s_init[8'(a)];
      for (int a = 0; a < 32; a++) begin
        rom_mem[5'(a)] <= rom_init[5'(a)];
        dec_mem[5'(a)] <= 8'h00;
      end
    end else begin
      if (bus.s_wren)       s_mem[bus.s_address] <= bus.s_data;
      if (bus.decrypt_wren) dec_mem[bus.decrypt_address] <= bus.decrypt_data;
    end
    bus.s_q   <= s_mem[bus.s_address];
    bus.rom_q <= rom_mem[bus.rom_address];
  end

  always @(negedge clock) if (bus.s_wren && bus.decrypt_wren) dual_wren++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_load();
    @(posedge clock); #1 load = 1'b1;
    @(posedge clock); #1 load = 1'b0;
  endtask

  task automatic identity_s();
    for (int a = 0; a < 256; a++) s_init[8'(a)] = 8'(a);
    for (int a = 0; a < 32; a++) rom_init[5'(a)] = 8'h00;
  endtask

  // Start at edge 0; cyc counts cycles after it. Returns on done, at stop_at,
  // or at the cycle budget. poke_at pulses start mid-run.
  task automatic run(input int stop_at, input int poke_at, output int cyc);
    @(posedge clock); #1 bus.start = 1'b1;
    @(posedge clock); #1 bus.start = 1'b0;
    cyc = 1;
    forever begin
      if (bus.done || cyc == stop_at || cyc >= 400) break;
      bus.start = (cyc == poke_at);
      @(posedge clock); #1;
      cyc++;
    end
    bus.start = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_done"},  32'(bus.done), 0);
    chk({tag, "_valid"}, 32'(bus.valid), 0);
    chk({tag, "_bytes"}, 32'(bus.bytes_done), 0);
    chk({tag, "_wren"},  32'({bus.s_wren, bus.decrypt_wren}), 0);
    chk({tag, "_addr"},  32'({bus.s_address, bus.rom_address, bus.decrypt_address}), 0);
    chk({tag, "_data"},  32'({bus.s_data, bus.decrypt_data}), 0);
  endtask

  // random S plus ROM crafted so the reference PRGA yields legal plaintext
  task automatic craft_random();
    logic [7:0] t, mi, mj, ks;
    int r;
    for (int a = 0; a < 256; a++) s_init[8'(a)] = 8'(a);
    for (int a = 255; a > 0; a--) begin
      r = $urandom_range(a, 0);
      t = s_init[8'(a)]; s_init[8'(a)] = s_init[8'(r)]; s_init[8'(r)] = t;
    end
    for (int a = 0; a < 256; a++) ms[8'(a)] = s_init[8'(a)];
    mi = 0; mj = 0;
    for (int n = 0; n < MSG_LEN; n++) begin
      r  = $urandom_range(26, 0);
      exp_pt[5'(n)] = (r == 26) ? 8'h20 : 8'h61 + 8'(r);
      mi = mi + 8'd1;
      mj = mj + ms[mi];
      t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
      t  = ms[mi] + ms[mj];
      ks = ms[t];
      rom_init[5'(n)] = exp_pt[5'(n)] ^ ks;
    end
  endtask

  task automatic chk_full_pass(input string tag, input int cyc);
    int bad;
    chk({tag, "_cyc"},   32'(cyc), 289);
    chk({tag, "_valid"}, 32'(bus.valid), 1);
    chk({tag, "_bytes"}, 32'(bus.bytes_done), 32);
    bad = 0;
    for (int a = 0; a < 32; a++) if (dec_mem[5'(a)] !== exp_pt[5'(a)]) bad++;
    chk({tag, "_plain"}, 32'(bad), 0);
    bad = 0;
    for (int a = 0; a < 256; a++) if (s_mem[8'(a)] !== ms[8'(a)]) bad++;
    chk({tag, "_s_final"}, 32'(bad), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, seen;
    bus.start = 1'b0;
    bus.halt  = 1'b0;
    reset     = 1'b1;
    identity_s();
    do_load();
    #1 chk_idle_outputs("reset");
    @(posedge clock); #1 reset = 1'b0;

    // two bytes: 0x61 legal, then 0x27 illegal at byte 1
    identity_s();
    rom_init[0] = 8'h63; rom_init[1] = 8'h22;
    do_load();
    run(0, 0, cyc);
    chk("A_cyc",   32'(cyc), 19);
    chk("A_valid", 32'(bus.valid), 0);
    chk("A_bytes", 32'(bus.bytes_done), 2);
    chk("A_dec0",  32'(dec_mem[0]), 32'h61);
    chk("A_dec1",  32'(dec_mem[1]), 32'h27);
    chk("A_s2",    32'(s_mem[2]), 3);
    chk("A_s3",    32'(s_mem[3]), 2);

    // first byte illegal: 0x00 ^ 0x02
    identity_s();
    do_load();
    run(0, 0, cyc);
    chk("B_cyc",   32'(cyc), 10);
    chk("B_valid", 32'(bus.valid), 0);
    chk("B_bytes", 32'(bus.bytes_done), 1);
    chk("B_dec0",  32'(dec_mem[0]), 32'h02);
    @(posedge clock); #1;
    chk("B_addr_idle", 32'({bus.s_address, bus.rom_address}), 0);

    // full 32-byte pass against the reference model, stray start at cycle 30
    craft_random();
    do_load();
    run(0, 30, cyc);
    chk_full_pass("C", cyc);
    @(posedge clock); #1;
    chk("C_done_pulse", 32'(bus.done), 0);
    chk("C_valid_held", 32'(bus.valid), 1);

    // halt in cycle 50 (WRITE_I of byte 5)
    do_load();
    run(50, 0, cyc);
    chk("H_cyc", 32'(cyc), 50);
    bus.halt = 1'b1;
    #1 chk("H_wren_halt", 32'({bus.s_wren, bus.decrypt_wren}), 0);
    @(posedge clock); #1 bus.halt = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.done || bus.s_wren || bus.decrypt_wren) seen++;
      @(posedge clock); #1;
    end
    chk("H_quiet",   32'(seen), 0);
    chk("H_valid",   32'(bus.valid), 0);
    chk("H_bytes",   32'(bus.bytes_done), 5);
    do_load();
    run(0, 0, cyc);
    chk_full_pass("H_rerun", cyc);

    // reset in cycle 20 of a run
    do_load();
    run(20, 0, cyc);
    chk("R_cyc", 32'(cyc), 20);
    reset = 1'b1;
    @(posedge clock); #1;
    chk_idle_outputs("R");
    reset = 1'b0;
    @(posedge clock); #1;
    chk("R_stays_idle", 32'({bus.done, bus.s_wren, bus.decrypt_wren}), 0);

    chk("one_wren", 32'(dual_wren), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
